// File: rtl/fp32_uart_pkg.sv
// fp32_uart_pkg
//   Shared definitions for the fp32 UART receive path: default clock and
//   line rate, the derived bit-period constants and the byte FSM state type.
//   No ports.
package fp32_uart_pkg;

   localparam logic [31:0] DEF_CLK_FREQ     = 32'd50_000_000;
   localparam logic [31:0] DEF_BAUD_RATE    = 32'd115_200;
   // Truncating divide: 50 MHz / 115 200 baud gives 434 clocks per bit.
   localparam logic [31:0] DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD_RATE;
   localparam logic [31:0] DEF_HALF_BIT     = DEF_CLKS_PER_BIT / 32'd2;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/fp32_uart_rx_if.sv
// fp32_uart_rx_if
//   Output bundle of the fp32 UART receiver towards the fp32 datapath.
//   rx_byte    : last correctly framed byte
//   byte_valid : one-cycle pulse when rx_byte updates
//   word       : last completed 32-bit word (first byte in [7:0])
//   word_valid : one-cycle pulse when word updates
//   frame_err  : one-cycle pulse when a stop bit samples low
//   master = receiver side (drives), slave = consumer side (samples).
interface fp32_uart_rx_if;

   logic [7:0]  rx_byte;
   logic        byte_valid;
   logic [31:0] word;
   logic        word_valid;
   logic        frame_err;

   modport master (output rx_byte, byte_valid, word, word_valid, frame_err);
   modport slave  (input  rx_byte, byte_valid, word, word_valid, frame_err);

endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 byte deserializer: 2-FF input synchronizer, start/data/stop bit FSM
//   and shift register, all timed by a 16-bit down-counting bit counter.
//   clk_i       : system clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   uart_rx_i   : asynchronous serial line, idles high
//   byte_o      : last correctly framed byte
//   valid_o     : one-cycle pulse when byte_o updates
//   frame_err_o : one-cycle pulse when the stop bit samples low
//   idle_o      : FSM is waiting for a start bit
module uart_rx_byte
   import fp32_uart_pkg::*;
#(
   parameter logic [31:0] CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       uart_rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       idle_o
);

   // First expiry lands in the middle of the start bit, later ones a full bit apart.
   localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 32'd2 - 32'd1);
   localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 32'd1);

   logic        meta_q, rx_q;
   logic        rx_s;
   logic        expired_s;
   rx_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   assign rx_s      = rx_q;
   assign expired_s = (cnt_q == 16'd0);

   // Two-flop synchronizer; both stages reset to the idle-high line level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         rx_q   <= 1'b1;
      end else begin
         meta_q <= uart_rx_i;
         rx_q   <= meta_q;
      end
   end

   // Bit FSM next-state, counter and shift register.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF_LOAD;
               state_d = RX_START;
            end else begin
               cnt_d   = 16'd0;
            end
         end
         RX_START: begin
            if (!expired_s) begin
               cnt_d = cnt_q - 16'd1;
            end else if (rx_s) begin
               // Line went back high before mid start bit: treat as a glitch.
               state_d = RX_IDLE;
            end else begin
               cnt_d     = FULL_LOAD;
               bit_idx_d = 3'd0;
               state_d   = RX_DATA;
            end
         end
         RX_DATA: begin
            if (!expired_s) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               // LSB arrives first, so shifting in at the top leaves it in [0].
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = FULL_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (!expired_s) begin
               cnt_d = cnt_q - 16'd1;
            end else begin
               // Leave at mid stop bit so a back-to-back start edge is not missed.
               state_d = RX_IDLE;
               if (rx_s) begin
                  byte_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   // FSM and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RX_IDLE;
         cnt_q     <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
         byte_q    <= 8'd0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign byte_o      = byte_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign idle_o      = (state_q == RX_IDLE);

endmodule

// File: rtl/fp32_uart_rx.sv
// fp32_uart_rx
//   UART receiver that packs four consecutive bytes (first byte in the low
//   lane) into a 32-bit word for the fp32 datapath. A partial word is dropped
//   after TIMEOUT_BITS idle bit-times or on a framing error.
//   clk_i     : system clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   uart_rx_i : asynchronous serial line, idles high
//   rx_if     : byte / word / framing-error outputs (master modport)
//   led1_o    : toggles on every completed word
//   led2_o    : sticky framing-error indicator, cleared only by reset
module fp32_uart_rx
   import fp32_uart_pkg::*;
#(
   parameter logic [31:0] CLK_FREQ     = DEF_CLK_FREQ,
   parameter logic [31:0] BAUD_RATE    = DEF_BAUD_RATE,
   parameter logic [31:0] CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
   parameter logic [31:0] TIMEOUT_BITS = 32'd20
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  uart_rx_i,
   fp32_uart_rx_if.master        rx_if,
   output logic                  led1_o,
   output logic                  led2_o
);

   localparam logic [31:0] TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;

   logic [7:0]  sub_byte_s;
   logic        sub_valid_s, sub_ferr_s, sub_idle_s;

   logic [7:0]  byte_q, byte_d;
   logic        byte_valid_q, byte_valid_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;
   logic        ferr_q, ferr_d;
   logic        led1_q, led1_d;
   logic        led2_q, led2_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] shadow_q, shadow_d;
   logic [31:0] idle_cnt_q, idle_cnt_d;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .uart_rx_i   (uart_rx_i),
      .byte_o      (sub_byte_s),
      .valid_o     (sub_valid_s),
      .frame_err_o (sub_ferr_s),
      .idle_o      (sub_idle_s)
   );

   // Word assembly, partial-word timeout and LED next-state.
   always_comb begin
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      word_d       = word_q;
      word_valid_d = 1'b0;
      ferr_d       = 1'b0;
      led1_d       = led1_q;
      led2_d       = led2_q;
      idx_d        = idx_q;
      shadow_d     = shadow_q;
      idle_cnt_d   = 32'd0;
      if (sub_valid_s) begin
         byte_d       = sub_byte_s;
         byte_valid_d = 1'b1;
         idx_d        = idx_q + 2'd1;   // wraps 3 -> 0
         case (idx_q)
            2'd0: shadow_d[7:0]   = sub_byte_s;
            2'd1: shadow_d[15:8]  = sub_byte_s;
            2'd2: shadow_d[23:16] = sub_byte_s;
            2'd3: begin
               word_d       = {sub_byte_s, shadow_q};
               word_valid_d = 1'b1;
               led1_d       = ~led1_q;
            end
            default: idx_d = 2'd0;
         endcase
      end else if (sub_ferr_s) begin
         ferr_d = 1'b1;
         led2_d = 1'b1;
         idx_d  = 2'd0;
      end else if (sub_idle_s && (idx_q != 2'd0)) begin
         // Only a word in progress can time out; the drop is silent.
         if (idle_cnt_q == (TIMEOUT_CLKS - 32'd1)) begin
            idx_d = 2'd0;
         end else begin
            idle_cnt_d = idle_cnt_q + 32'd1;
         end
      end else begin
         idle_cnt_d = 32'd0;
      end
   end

   // Output and word-assembly registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_q       <= 8'd0;
         byte_valid_q <= 1'b0;
         word_q       <= 32'd0;
         word_valid_q <= 1'b0;
         ferr_q       <= 1'b0;
         led1_q       <= 1'b0;
         led2_q       <= 1'b0;
         idx_q        <= 2'd0;
         shadow_q     <= 24'd0;
         idle_cnt_q   <= 32'd0;
      end else begin
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         ferr_q       <= ferr_d;
         led1_q       <= led1_d;
         led2_q       <= led2_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

   assign rx_if.rx_byte    = byte_q;
   assign rx_if.byte_valid = byte_valid_q;
   assign rx_if.word       = word_q;
   assign rx_if.word_valid = word_valid_q;
   assign rx_if.frame_err  = ferr_q;
   assign led1_o           = led1_q;
   assign led2_o           = led2_q;

endmodule

// File: tb/tb_fp32_uart_rx.sv
// tb_fp32_uart_rx
//   Self-checking bench for fp32_uart_rx. The receiver runs with a scaled
//   clock (100 clocks per bit) so the run stays short; every bit time below
//   is derived from CPB. A queue-based model predicts bytes, words, framing
//   errors and LED levels; a monitor records what the receiver emits.
module tb_fp32_uart_rx;

   localparam int CPB      = 100;
   localparam int CPB_SLOW = 103;   // +3 %
   localparam int CPB_FAST = 97;    // -3 %

   logic clk = 1'b0;
   logic rst_ni = 1'b1;
   logic uart_rx_i = 1'b1;
   logic led1_o, led2_o;

   fp32_uart_rx_if bus ();

   fp32_uart_rx #(
      .CLK_FREQ  (32'd11_520_000),
      .BAUD_RATE (32'd115_200)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .uart_rx_i (uart_rx_i),
      .rx_if     (bus),
      .led1_o    (led1_o),
      .led2_o    (led2_o)
   );

   always #10 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  obs_bytes[$];
   logic [7:0]  exp_bytes[$];
   logic [7:0]  part[$];
   logic [31:0] obs_words[$];
   logic [31:0] exp_words[$];
   int          obs_ferr = 0;
   int          exp_ferr = 0;
   logic        exp_led1 = 1'b0;
   logic        exp_led2 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Record every pulse the receiver produces.
   always @(negedge clk) begin
      if (rst_ni) begin
         if (bus.byte_valid) obs_bytes.push_back(bus.rx_byte);
         if (bus.word_valid) begin
            obs_words.push_back(bus.word);
            chk("word_with_byte", 32'(bus.byte_valid), 32'd1);
         end
         if (bus.frame_err) obs_ferr++;
      end
   end

   // ---------------- reference model ----------------
   task automatic model_byte(input logic [7:0] b);
      exp_bytes.push_back(b);
      part.push_back(b);
      if (part.size() == 4) begin
         exp_words.push_back({part[3], part[2], part[1], part[0]});
         exp_led1 = ~exp_led1;
         part.delete();
      end
   endtask

   task automatic model_ferr();
      exp_ferr++;
      exp_led2 = 1'b1;
      part.delete();
   endtask

   task automatic model_timeout();
      part.delete();
   endtask

   task automatic model_reset();
      part.delete();
      exp_led1 = 1'b0;
      exp_led2 = 1'b0;
   endtask

   // ---------------- line driver ----------------
   // abort_bit >= 0 stops half way through that data bit and leaves the line as is.
   task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_bit,
                             input int abort_bit);
      uart_rx_i = 1'b0;
      repeat (cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = b[i];
         if (i == abort_bit) begin
            repeat (cpb / 2) @(negedge clk);
            return;
         end
         repeat (cpb) @(negedge clk);
      end
      uart_rx_i = stop_bit;
      // A low stop bit is released early so the line is clearly idle when the receiver re-arms.
      if (stop_bit) repeat (cpb) @(negedge clk);
      else          repeat (cpb / 2 + cpb / 4) @(negedge clk);
      uart_rx_i = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b, input int cpb);
      send_frame(b, cpb, 1'b1, -1);
      model_byte(b);
   endtask

   task automatic idle_bits(input int nbits);
      uart_rx_i = 1'b1;
      repeat (nbits * CPB) @(negedge clk);
   endtask

   task automatic checkpoint(input string tag);
      int n;
      repeat (4) @(negedge clk);
      chk({tag, "/nbytes"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
      n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
      for (int i = 0; i < n; i++) chk({tag, "/byte"}, 32'(obs_bytes[i]), 32'(exp_bytes[i]));
      chk({tag, "/nwords"}, 32'(obs_words.size()), 32'(exp_words.size()));
      n = (obs_words.size() < exp_words.size()) ? obs_words.size() : exp_words.size();
      for (int i = 0; i < n; i++) chk({tag, "/word"}, obs_words[i], exp_words[i]);
      chk({tag, "/ferr"}, 32'(obs_ferr), 32'(exp_ferr));
      chk({tag, "/led1"}, 32'(led1_o), 32'(exp_led1));
      chk({tag, "/led2"}, 32'(led2_o), 32'(exp_led2));
      obs_bytes.delete(); exp_bytes.delete();
      obs_words.delete(); exp_words.delete();
      obs_ferr = 0; exp_ferr = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "/byte_o"},       32'(bus.rx_byte),    32'd0);
      chk({tag, "/byte_valid_o"}, 32'(bus.byte_valid), 32'd0);
      chk({tag, "/word_o"},       bus.word,            32'd0);
      chk({tag, "/word_valid_o"}, 32'(bus.word_valid), 32'd0);
      chk({tag, "/frame_err_o"},  32'(bus.frame_err),  32'd0);
      chk({tag, "/led1_o"},       32'(led1_o),         32'd0);
      chk({tag, "/led2_o"},       32'(led2_o),         32'd0);
   endtask

   initial begin
      logic [7:0] b;
      #5 rst_ni = 1'b0;
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      rst_ni = 1'b1;
      repeat (10) @(negedge clk);

      // Word assembly, zero gap between frames.
      send_good(8'h30, CPB); send_good(8'h31, CPB);
      send_good(8'h32, CPB); send_good(8'h33, CPB);
      checkpoint("word");

      // Glitches shorter than half a bit are ignored.
      uart_rx_i = 1'b0; repeat (CPB / 4) @(negedge clk); uart_rx_i = 1'b1;
      idle_bits(2);
      uart_rx_i = 1'b0; repeat ($urandom_range(5, 40)) @(negedge clk); uart_rx_i = 1'b1;
      idle_bits(2);
      send_good(8'h55, CPB);
      checkpoint("glitch");
      idle_bits(21); model_timeout();

      // Framing error in the middle of a word.
      send_good(8'($urandom), CPB); send_good(8'($urandom), CPB);
      send_frame(8'hA5, CPB, 1'b0, -1); model_ferr();
      idle_bits(2);
      send_good(8'h01, CPB); send_good(8'h02, CPB);
      send_good(8'h03, CPB); send_good(8'h04, CPB);
      checkpoint("ferr");

      // Partial word dropped after an idle timeout.
      send_good(8'($urandom), CPB); send_good(8'($urandom), CPB);
      idle_bits(21); model_timeout();
      send_good(8'h11, CPB); send_good(8'h22, CPB);
      send_good(8'h33, CPB); send_good(8'h44, CPB);
      checkpoint("timeout");

      // Reset during data bit 4 of the third byte.
      send_good(8'($urandom), CPB); send_good(8'($urandom), CPB);
      checkpoint("pre_reset");
      send_frame(8'($urandom), CPB, 1'b1, 4);
      rst_ni = 1'b0;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      uart_rx_i = 1'b1;
      repeat (20) @(negedge clk);
      rst_ni = 1'b1;
      idle_bits(2);
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         send_good(b, CPB);
         if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 3));
      end
      checkpoint("after_reset");

      // Baud skew of +/-3 %.
      send_good(8'hEF, CPB_FAST); send_good(8'hBE, CPB_FAST);
      send_good(8'hAD, CPB_FAST); send_good(8'hDE, CPB_FAST);
      send_good(8'hEF, CPB_SLOW); send_good(8'hBE, CPB_SLOW);
      send_good(8'hAD, CPB_SLOW); send_good(8'hDE, CPB_SLOW);
      checkpoint("skew");

      // Random bytes with small random gaps and slight rate offsets.
      for (int i = 0; i < 4; i++) begin
         send_good(8'($urandom), int'($urandom_range(98, 102)));
         idle_bits($urandom_range(0, 2));
      end
      checkpoint("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
